// File: rtl/axi_cdc_src_isolate.sv
// Quiesce controller for the source half of an AXI CDC: blocks new AW/AR on request,
// drains outstanding W/B/R traffic, then reports the port isolated.

package axi_cdc_src_isolate_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_cdc_src_isolate #(
  parameter int unsigned MaxTxns = 8,
  parameter type axi_req_t  = axi_cdc_src_isolate_pkg::axi_req_t,
  parameter type axi_resp_t = axi_cdc_src_isolate_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      isolate_i,
  output logic      isolated_o,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  localparam int unsigned CW = $clog2(MaxTxns + 1);
  localparam logic [CW-1:0] CntMax = CW'(MaxTxns);

  typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic signed [CW:0]  w_bal_q, w_bal_d;
  logic                aw_hold_q, ar_hold_q, w_hold_q, w_mid_q, isolated_q;
  logic                aw_open, ar_open, w_open;
  logic                aw_hs, ar_hs, w_hs, w_last_hs, b_hs, r_last_hs;
  logic                bal_neg, bal_zero, bal_pos, drained;

  assign bal_neg  = w_bal_q[CW];
  assign bal_zero = (w_bal_q == '0);
  assign bal_pos  = !bal_neg && !bal_zero;

  // B/R completions depend only on inputs, so a freeing handshake can reopen a
  // saturated AW/AR gate in the same cycle without a combinational loop.
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  assign aw_open = !rst_i && (aw_hold_q ||
                   ((state_q == NORMAL || (state_q == DRAIN && bal_neg)) &&
                    (wr_cnt_q < CntMax || b_hs)));
  assign ar_open = !rst_i && (ar_hold_q ||
                   (state_q == NORMAL && (rd_cnt_q < CntMax || r_last_hs)));
  assign w_open  = !rst_i && (w_hold_q || state_q == NORMAL ||
                   (state_q == DRAIN && (bal_pos || w_mid_q)));

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open;
    mst_req_o.w_valid   = slv_req_i.w_valid & w_open;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign w_hs      = mst_req_o.w_valid & mst_resp_i.w_ready;
  assign w_last_hs = w_hs & slv_req_i.w.last;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    w_bal_d  = w_bal_q;
    unique case ({aw_hs, b_hs})
      2'b10:   if (wr_cnt_q != CntMax) wr_cnt_d = wr_cnt_q + CW'(1);
      2'b01:   if (wr_cnt_q != '0)     wr_cnt_d = wr_cnt_q - CW'(1);
      default: wr_cnt_d = wr_cnt_q;
    endcase
    unique case ({ar_hs, r_last_hs})
      2'b10:   if (rd_cnt_q != CntMax) rd_cnt_d = rd_cnt_q + CW'(1);
      2'b01:   if (rd_cnt_q != '0)     rd_cnt_d = rd_cnt_q - CW'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
    unique case ({aw_hs, w_last_hs})
      2'b10:   w_bal_d = w_bal_q + (CW+1)'(1);
      2'b01:   w_bal_d = w_bal_q - (CW+1)'(1);
      default: w_bal_d = w_bal_q;
    endcase
  end

  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && bal_zero &&
                   !aw_hold_q && !ar_hold_q && !w_hold_q && !w_mid_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL:   if (isolate_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_i)   state_d = NORMAL;
        else if (drained) state_d = ISOLATED;
      end
      ISOLATED: if (!isolate_i) state_d = NORMAL;
      default:  state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= NORMAL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      w_bal_q    <= '0;
      aw_hold_q  <= 1'b0;
      ar_hold_q  <= 1'b0;
      w_hold_q   <= 1'b0;
      w_mid_q    <= 1'b0;
      isolated_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      w_bal_q    <= w_bal_d;
      aw_hold_q  <= mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
      ar_hold_q  <= mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
      w_hold_q   <= mst_req_o.w_valid & ~mst_resp_i.w_ready;
      if (w_hs) w_mid_q <= ~slv_req_i.w.last;
      isolated_q <= (state_d == ISOLATED);
    end
  end

  assign isolated_o = isolated_q;

  // A completion with nothing outstanding means the downstream broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i) !(b_hs && wr_cnt_q == '0));
  assert property (@(posedge clk_i) disable iff (rst_i) !(r_last_hs && rd_cnt_q == '0));

endmodule

// File: tb/tb_axi_cdc_src_isolate.sv
// Bench for axi_cdc_src_isolate: pass-through vector table, drain/isolate sequences,
// and a scoreboard for AW addresses and R data crossing the block.

module tb_axi_cdc_src_isolate;
  import axi_cdc_src_isolate_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      isolate;
  logic      isolated;
  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;

  int ntests = 0;
  int nfail  = 0;
  bit sb_on  = 1'b0;
  logic [31:0] aw_q[$];
  logic [31:0] r_q[$];

  typedef struct {
    string       name;
    logic [10:0] stim;
    logic [9:0]  exp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  axi_cdc_src_isolate #(
    .MaxTxns    (8),
    .axi_req_t  (axi_req_t),
    .axi_resp_t (axi_resp_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .isolate_i  (isolate),
    .isolated_o (isolated),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    slv_req  = '0;
    mst_resp = '0;
  endtask

  task automatic do_reset();
    idle();
    isolate = 1'b0;
    rst     = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // stim bits: {aw_v, aw_r, w_v, w_r, ar_v, ar_r, b_v, b_r, r_v, r_r, r_last}
  task automatic apply(input logic [10:0] s);
    slv_req.aw_valid  = s[10];
    mst_resp.aw_ready = s[9];
    slv_req.w_valid   = s[8];
    mst_resp.w_ready  = s[7];
    slv_req.ar_valid  = s[6];
    mst_resp.ar_ready = s[5];
    mst_resp.b_valid  = s[4];
    slv_req.b_ready   = s[3];
    mst_resp.r_valid  = s[2];
    slv_req.r_ready   = s[1];
    mst_resp.r.last   = s[0];
    slv_req.w.last    = 1'b1;
  endtask

  function automatic logic [9:0] sample();
    return {mst_req.aw_valid, slv_resp.aw_ready, mst_req.w_valid, slv_resp.w_ready,
            mst_req.ar_valid, slv_resp.ar_ready, slv_resp.b_valid, mst_req.b_ready,
            slv_resp.r_valid, mst_req.r_ready};
  endfunction

  always @(negedge clk) begin
    if (sb_on) begin
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        check("sb_aw_pending", 32'(aw_q.size() != 0), 32'd1);
        if (aw_q.size() != 0) check("sb_aw_addr", mst_req.aw.addr, aw_q.pop_front());
      end
      if (slv_resp.r_valid && slv_req.r_ready) begin
        check("sb_r_pending", 32'(r_q.size() != 0), 32'd1);
        if (r_q.size() != 0) check("sb_r_data", slv_resp.r.data, r_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"aw_hs",        11'b11_00_00_00_000, 10'b11_00_00_00_00};
    vecs[1] = '{"w_hs",         11'b00_11_00_00_000, 10'b00_11_00_00_00};
    vecs[2] = '{"aw_stall",     11'b10_00_00_00_000, 10'b10_00_00_00_00};
    vecs[3] = '{"aw_hs2",       11'b11_00_00_00_000, 10'b11_00_00_00_00};
    vecs[4] = '{"b_hs_w_stall", 11'b00_10_00_11_000, 10'b00_10_00_11_00};
    vecs[5] = '{"w_b_hs",       11'b00_11_00_11_000, 10'b00_11_00_11_00};
    vecs[6] = '{"ar_hs",        11'b00_00_11_00_000, 10'b00_00_11_00_00};
    vecs[7] = '{"r_mid",        11'b00_00_00_00_110, 10'b00_00_00_00_11};
    vecs[8] = '{"r_last",       11'b00_00_00_00_111, 10'b00_00_00_00_11};
    vecs[9] = '{"r_ready_only", 11'b00_00_00_00_010, 10'b00_00_00_00_01};

    // Reset: valids masked while rst is high.
    idle();
    isolate = 1'b0;
    rst     = 1'b1;
    tick();
    slv_req.aw_valid  = 1'b1;
    slv_req.w_valid   = 1'b1;
    slv_req.ar_valid  = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.ar_ready = 1'b1;
    settle();
    check("rst_mst_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid}, 3'b000);
    check("rst_slv_readies", {slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready}, 3'b000);
    check("rst_isolated", isolated, 1'b0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    settle();
    check("post_rst_isolated", isolated, 1'b0);

    // Normal operation: zero-latency pass-through.
    for (int i = 0; i < 10; i++) begin
      tick();
      apply(vecs[i].stim);
      settle();
      check(vecs[i].name, sample(), vecs[i].exp);
    end
    tick();
    idle();
    settle();
    check("table_isolated", isolated, 1'b0);

    // Three 4-beat reads outstanding, then drain.
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      slv_req.ar_valid  = 1'b1;
      slv_req.ar.addr   = 32'h100 + 32'(i);
      slv_req.ar.len    = 8'd3;
      mst_resp.ar_ready = 1'b1;
    end
    tick();
    idle();
    isolate = 1'b1;
    tick();
    slv_req.ar_valid  = 1'b1;
    mst_resp.ar_ready = 1'b1;
    settle();
    check("drain_ar_ready", slv_resp.ar_ready, 1'b0);
    check("drain_ar_valid", mst_req.ar_valid, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      slv_req.ar_valid  = 1'b0;
      mst_resp.ar_ready = 1'b0;
      mst_resp.r_valid  = 1'b1;
      mst_resp.r.data   = 32'hA000 + 32'(i);
      mst_resp.r.last   = (i % 4 == 3);
      slv_req.r_ready   = 1'b1;
      r_q.push_back(32'hA000 + 32'(i));
      if (i == 11) begin
        settle();
        check("rd_iso_last_beat", isolated, 1'b0);
      end
    end
    tick();
    idle();
    settle();
    check("rd_iso_e1", isolated, 1'b0);
    tick();
    settle();
    check("rd_iso_e2", isolated, 1'b1);
    isolate = 1'b0;
    tick();
    mst_resp.ar_ready = 1'b1;
    settle();
    check("rd_release_iso", isolated, 1'b0);
    check("rd_ar_reopen", slv_resp.ar_ready, 1'b1);
    sb_on = 1'b0;
    check("rd_sb_empty", r_q.size(), 0);

    // Write saturation at MaxTxns; a B handshake frees a slot in the same cycle.
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      slv_req.aw_valid  = 1'b1;
      slv_req.aw.addr   = 32'h1000 + 32'(i * 16);
      mst_resp.aw_ready = 1'b1;
      aw_q.push_back(32'h1000 + 32'(i * 16));
    end
    tick();
    slv_req.aw.addr = 32'h2000;
    aw_q.push_back(32'h2000);
    settle();
    check("sat_aw_ready", slv_resp.aw_ready, 1'b0);
    check("sat_aw_valid", mst_req.aw_valid, 1'b0);
    tick();
    mst_resp.b_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    settle();
    check("sat_b_aw_ready", slv_resp.aw_ready, 1'b1);
    tick();
    mst_resp.b_valid = 1'b0;
    slv_req.b_ready  = 1'b0;
    slv_req.aw.addr  = 32'h2004;
    settle();
    check("sat_still_full", slv_resp.aw_ready, 1'b0);
    idle();
    sb_on = 1'b0;
    check("sat_sb_empty", aw_q.size(), 0);

    // W before its AW: AW still admitted during drain while w_bal < 0.
    do_reset();
    sb_on = 1'b1;
    tick();
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b1;
    slv_req.w.data   = 32'h55;
    mst_resp.w_ready = 1'b1;
    settle();
    check("early_w_valid", mst_req.w_valid, 1'b1);
    tick();
    idle();
    isolate = 1'b1;
    tick();
    slv_req.aw_valid  = 1'b1;
    slv_req.aw.addr   = 32'h3000;
    mst_resp.aw_ready = 1'b1;
    aw_q.push_back(32'h3000);
    settle();
    check("drain_aw_neg_bal", mst_req.aw_valid, 1'b1);
    tick();
    slv_req.aw.addr = 32'h3004;
    settle();
    check("drain_aw_zero_bal", mst_req.aw_valid, 1'b0);
    slv_req.aw_valid  = 1'b0;
    mst_resp.aw_ready = 1'b0;
    mst_resp.b_valid  = 1'b1;
    slv_req.b_ready   = 1'b1;
    settle();
    check("early_iso_b", isolated, 1'b0);
    tick();
    idle();
    settle();
    check("early_iso_e1", isolated, 1'b0);
    tick();
    settle();
    check("early_iso_e2", isolated, 1'b1);
    slv_req.w_valid  = 1'b1;
    mst_resp.w_ready = 1'b1;
    settle();
    check("iso_w_closed", {mst_req.w_valid, slv_resp.w_ready}, 2'b00);
    idle();
    isolate = 1'b0;
    tick();
    settle();
    check("early_release", isolated, 1'b0);
    sb_on = 1'b0;
    check("early_sb_empty", aw_q.size(), 0);

    // AW stalled downstream when isolate rises: valid must never retract.
    do_reset();
    sb_on = 1'b1;
    tick();
    slv_req.aw_valid  = 1'b1;
    slv_req.aw.addr   = 32'h4000;
    mst_resp.aw_ready = 1'b0;
    aw_q.push_back(32'h4000);
    isolate = 1'b1;
    settle();
    check("stall_aw_normal", mst_req.aw_valid, 1'b1);
    tick();
    settle();
    check("stall_aw_drain", mst_req.aw_valid, 1'b1);
    tick();
    mst_resp.aw_ready = 1'b1;
    settle();
    check("stall_aw_hs", slv_resp.aw_ready, 1'b1);
    tick();
    idle();
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b0;
    mst_resp.w_ready = 1'b1;
    settle();
    check("stall_w_beat0", mst_req.w_valid, 1'b1);
    tick();
    slv_req.w.last = 1'b1;
    settle();
    check("stall_w_beat1", mst_req.w_valid, 1'b1);
    tick();
    settle();
    check("stall_w_closed", mst_req.w_valid, 1'b0);
    idle();
    mst_resp.b_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    settle();
    check("stall_iso_b", isolated, 1'b0);
    tick();
    idle();
    settle();
    check("stall_iso_e1", isolated, 1'b0);
    tick();
    settle();
    check("stall_iso_e2", isolated, 1'b1);
    isolate = 1'b0;
    tick();
    sb_on = 1'b0;
    check("stall_sb_empty", aw_q.size(), 0);

    // Abort drain, then reset in the middle of a burst.
    do_reset();
    tick();
    slv_req.ar_valid  = 1'b1;
    mst_resp.ar_ready = 1'b1;
    tick();
    idle();
    isolate = 1'b1;
    tick();
    mst_resp.ar_ready = 1'b1;
    settle();
    check("abort_drain_ar", slv_resp.ar_ready, 1'b0);
    isolate = 1'b0;
    tick();
    settle();
    check("abort_ar_reopen", slv_resp.ar_ready, 1'b1);
    check("abort_isolated", isolated, 1'b0);
    mst_resp.ar_ready = 1'b0;
    slv_req.aw_valid  = 1'b1;
    mst_resp.aw_ready = 1'b1;
    tick();
    idle();
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b0;
    mst_resp.w_ready = 1'b1;
    tick();
    rst = 1'b1;
    slv_req.aw_valid  = 1'b1;
    slv_req.ar_valid  = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    settle();
    check("midrst_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid}, 3'b000);
    tick();
    idle();
    rst = 1'b0;
    settle();
    check("midrst_isolated", isolated, 1'b0);
    isolate = 1'b1;
    tick();
    settle();
    check("midrst_iso_e1", isolated, 1'b0);
    tick();
    settle();
    check("midrst_iso_e2", isolated, 1'b1);
    isolate = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
